// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

   // Next-PC source selected each edge
   typedef enum logic [1:0] {
      PC_ADV   = 2'd0,
      PC_HOLD  = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_e;

   // IF/ID pipeline register contents
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc4;
      logic              valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc4: '0, valid: 1'b0};

   // Sequential PC successor; wraps modulo 2^ADDR_W by construction
   function automatic logic [ADDR_W-1:0] pc_plus_step(input logic [ADDR_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect / hold / sequential next-PC mux.
module fetch_pc_reg
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  pc_sel_e           sel,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;

   // Next-PC selection
   always_comb begin
      pc_d = pc_plus_step(pc);
      case (sel)
         PC_REDIR: pc_d = redirect_pc;
         PC_HOLD:  pc_d = pc;
         default:  pc_d = pc_plus_step(pc);
      endcase
   end

   // PC register, loads RESET_PC asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_d;
   end

endmodule

// File: rtl/inst_fetch_stage.sv
// IF stage: drives the instruction-memory address from the PC, captures the
// returned word into IF/ID, and counts valid fetches.
// Optional macro FETCH_ALIGN_CHECK_EN: trap misaligned PCs into a sticky
// misalign flag, inserting bubbles and holding the PC until a redirect.
module inst_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [INST_W-1:0] ifid_inst,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic              ifid_valid,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic              misalign
);

   logic [ADDR_W-1:0] pc_q;
   logic              bad_pc;
   logic              advance;
   pc_sel_e           pc_sel;
   ifid_t             ifid_q;

`ifdef FETCH_ALIGN_CHECK_EN
   // A misaligned PC blocks sequential fetch; it stays misaligned until redirected
   assign bad_pc = (pc_q[1:0] != 2'b00);
`else
   assign bad_pc = 1'b0;
`endif

   // redirect outranks stall so a wrong-path word is never latched
   assign advance = !redirect && !stall;

   // PC source: a bad PC holds like a stall so the faulting address stays visible
   always_comb begin
      pc_sel = PC_ADV;
      if (redirect)             pc_sel = PC_REDIR;
      else if (stall || bad_pc) pc_sel = PC_HOLD;
   end

   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (pc_sel),
      .redirect_pc (redirect_pc),
      .pc          (pc_q)
   );

   assign imem_addr = pc_q;

   // IF/ID register: flush on redirect, hold on stall, bubble on bad PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                ifid_q <= IFID_BUBBLE;
      else if (redirect)         ifid_q <= IFID_BUBBLE;
      else if (advance) begin
         if (bad_pc) ifid_q <= IFID_BUBBLE;
         else        ifid_q <= '{inst: imem_inst, pc4: pc_plus_step(pc_q), valid: 1'b1};
      end
   end

   // Count only words latched valid; wraps naturally at CNT_W bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  fetch_cnt <= '0;
      else if (advance && !bad_pc) fetch_cnt <= fetch_cnt + CNT_W'(1);
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky misalign flag; only a redirect (or reset) clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 misalign <= 1'b0;
      else if (redirect)          misalign <= 1'b0;
      else if (advance && bad_pc) misalign <= 1'b1;
   end
`else
   assign misalign = 1'b0;
`endif

   assign ifid_inst  = ifid_q.inst;
   assign ifid_pc4   = ifid_q.pc4;
   assign ifid_valid = ifid_q.valid;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed bench for inst_fetch_stage with an expected-result queue.
// Main instance uses RESET_PC=0; a second instance starts near the top of
// the address space with a 2-bit counter to cover PC and counter wrap.
module tb_inst_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [31:0] fetch_cnt;
   logic        misalign;

   logic        rst_hi_n;
   logic [31:0] hi_addr;
   logic [31:0] hi_inst;
   logic [31:0] hi_ifid_inst;
   logic [31:0] hi_ifid_pc4;
   logic        hi_ifid_valid;
   logic [1:0]  hi_cnt;
   logic        hi_misalign;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   // bench reference state
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_cnt;
   logic        m_mis;

   // instruction memory image: program words at 0..12, address-derived elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0022_1820;
         32'h4:   return 32'h2023_0004;
         32'h8:   return 32'h2423_0004;
         32'hC:   return 32'h0000_0000;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign imem_inst = mem_word(imem_addr);
   assign hi_inst   = mem_word(hi_addr);

   inst_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_inst   (imem_inst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ifid_inst   (ifid_inst),
      .ifid_pc4    (ifid_pc4),
      .ifid_valid  (ifid_valid),
      .fetch_cnt   (fetch_cnt),
      .misalign    (misalign)
   );

   inst_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut_hi (
      .clk         (clk),
      .rst_n       (rst_hi_n),
      .imem_addr   (hi_addr),
      .imem_inst   (hi_inst),
      .stall       (1'b0),
      .redirect    (1'b0),
      .redirect_pc (32'h0),
      .ifid_inst   (hi_ifid_inst),
      .ifid_pc4    (hi_ifid_pc4),
      .ifid_valid  (hi_ifid_valid),
      .fetch_cnt   (hi_cnt),
      .misalign    (hi_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
   endtask

   // drive one edge's inputs, push the expected post-edge state, then compare
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      exp_t e;
      exp_t g;
      stall = st; redirect = rd; redirect_pc = rpc;
      if (rd) begin
         m_pc = rpc; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
      end else if (!st) begin
`ifdef FETCH_ALIGN_CHECK_EN
         if (m_pc[1:0] != 2'b00) begin
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b1;
         end else
`endif
         begin
            m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
         end
      end
      e.addr = m_pc; e.inst = m_inst; e.pc4 = m_pc4;
      e.valid = m_valid; e.cnt = m_cnt; e.mis = m_mis;
      sb.push_back(e);
      @(posedge clk); #1;
      g = sb.pop_front();
      chk("imem_addr",  imem_addr,  g.addr);
      chk("ifid_inst",  ifid_inst,  g.inst);
      chk("ifid_pc4",   ifid_pc4,   g.pc4);
      chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, g.valid});
      chk("fetch_cnt",  fetch_cnt,  g.cnt);
      chk("misalign",   {31'b0, misalign}, {31'b0, g.mis});
   endtask

   initial begin
      rst_n = 1'b0; rst_hi_n = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #2;
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_inst",  ifid_inst, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_cnt",   fetch_cnt, 32'h0);
      chk("rst_mis",   {31'b0, misalign}, 32'h0);
      #10 rst_n = 1'b1;                       // released between edges (t=12)

      // free-running fetch to pc=8
      step(0, 0, 0);
      chk("t1_inst0", ifid_inst, 32'h0022_1820);
      step(0, 0, 0);
      chk("t1_addr8", imem_addr, 32'h8);

      // stall holds PC, IF/ID and the counter
      repeat (3) step(1, 0, 0);
      chk("t2_hold_inst", ifid_inst, 32'h2023_0004);
      chk("t2_hold_cnt",  fetch_cnt, 32'd2);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("t1_cnt4",  fetch_cnt, 32'd4);
      chk("t1_inst3", ifid_inst, 32'h0);

      // redirect wins over a simultaneous stall
      step(1, 1, 32'h40);
      chk("t3_flush_valid", {31'b0, ifid_valid}, 32'h0);
      step(0, 0, 0);
      chk("t3_tgt_inst", ifid_inst, 32'h5A5A_0040);

      // misaligned redirect target
      step(0, 1, 32'h42);
      step(0, 0, 0);
      step(0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("t6_mis_set",  {31'b0, misalign}, 32'h1);
      chk("t6_pc_held",  imem_addr, 32'h42);
      step(0, 1, 32'h44);
      chk("t6_mis_clr",  {31'b0, misalign}, 32'h0);
`else
      chk("t6_no_check", imem_addr, 32'h4A);
`endif
      step(0, 0, 0);

      // async reset mid-stream at pc=0x20
      step(0, 1, 32'h1C);
      step(0, 0, 0);
      chk("t5_pc20", imem_addr, 32'h20);
      #2 rst_n = 1'b0;                         // between edges
      #1;
      model_reset();
      chk("t5_clr_addr",  imem_addr, 32'h0);
      chk("t5_clr_valid", {31'b0, ifid_valid}, 32'h0);
      chk("t5_clr_cnt",   fetch_cnt, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      chk("t5_rel_addr", imem_addr, 32'h0);
      step(0, 0, 0);
      chk("t5_first_inst", ifid_inst, 32'h0022_1820);

      // PC wrap and CNT_W=2 counter wrap on the high-RESET_PC instance
      @(negedge clk) rst_hi_n = 1'b1;
      chk("t4_addr0", hi_addr, 32'hFFFF_FFF8);
      chk("t4_valid0", {31'b0, hi_ifid_valid}, 32'h0);
      @(posedge clk); #1;
      chk("t4_addr1", hi_addr, 32'hFFFF_FFFC);
      chk("t4_pc4_1", hi_ifid_pc4, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      chk("t4_addr2", hi_addr, 32'h0000_0000);
      chk("t4_pc4_2", hi_ifid_pc4, 32'h0000_0000);
      chk("t4_inst2", hi_ifid_inst, 32'hA5A5_FFFC);
      @(posedge clk); #1;
      chk("t4_cnt3", {30'b0, hi_cnt}, 32'd3);
      @(posedge clk); #1;
      chk("t4_cnt_wrap", {30'b0, hi_cnt}, 32'd0);
      chk("t4_mis", {31'b0, hi_misalign}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // watchdog keeps the run bounded
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
